// File: rtl/icache_ctrl_if.sv
// Fetch, data-RAM and refill signals of the I-cache controller.
// master: controller side; slave: core/RAM/memory side.
interface icache_ctrl_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int LINE_WIDTH = 512,
   parameter int INDEX_BITS = 5
) ();
   logic                  fetch_req_i;
   logic [ADDR_WIDTH-1:0] fetch_addr_i;
   logic                  fetch_gnt_o;
   logic                  fetch_valid_o;
   logic [31:0]           fetch_instr_o;
   logic                  flush_i;
   logic [INDEX_BITS-1:0] ram_addr_o;
   logic [LINE_WIDTH-1:0] ram_data_o;
   logic                  ram_we_o;
   logic [LINE_WIDTH-1:0] ram_data_i;
   logic                  mem_req_o;
   logic [ADDR_WIDTH-1:0] mem_addr_o;
   logic                  mem_ack_i;
   logic [LINE_WIDTH-1:0] mem_data_i;

   modport master (
      input  fetch_req_i, fetch_addr_i, flush_i,
      input  ram_data_i, mem_ack_i, mem_data_i,
      output fetch_gnt_o, fetch_valid_o, fetch_instr_o,
      output ram_addr_o, ram_data_o, ram_we_o,
      output mem_req_o, mem_addr_o
   );

   modport slave (
      output fetch_req_i, fetch_addr_i, flush_i,
      output ram_data_i, mem_ack_i, mem_data_i,
      input  fetch_gnt_o, fetch_valid_o, fetch_instr_o,
      input  ram_addr_o, ram_data_o, ram_we_o,
      input  mem_req_o, mem_addr_o
   );
endinterface

// File: rtl/icache_ctrl.sv
// Direct-mapped I-cache controller: tag/valid arrays, data RAM sequencing,
// single-beat line refill. Ports: clk, rst (async active-low), bus (master).
module icache_ctrl #(
   parameter int ADDR_WIDTH = 32,
   parameter int LINE_WIDTH = 512,
   parameter int INDEX_BITS = 5
) (
   input  logic          clk,
   input  logic          rst,
   icache_ctrl_if.master bus
);
   localparam int OFFSET_BITS   = $clog2(LINE_WIDTH / 8);
   localparam int WORD_SEL_BITS = OFFSET_BITS - 2;
   localparam int TAG_BITS      = ADDR_WIDTH - INDEX_BITS - OFFSET_BITS;
   localparam int SETS          = 1 << INDEX_BITS;

   typedef enum logic [1:0] {
      IDLE,
      LOOKUP,
      MISS,
      FILL
   } state_t;

   state_t state_q;
   state_t state_d;

   logic [ADDR_WIDTH-1:2]    req_addr;
   logic [SETS-1:0]          valid_q;
   logic [TAG_BITS-1:0]      tag_arr [SETS];
   logic                     flush_pend;
   logic [LINE_WIDTH-1:0]    fill_buf;
   logic [31:0]              last_instr;

   logic [TAG_BITS-1:0]      req_tag;
   logic [INDEX_BITS-1:0]    req_index;
   logic [WORD_SEL_BITS-1:0] req_word;
   logic [INDEX_BITS-1:0]    f_index;
   logic [31:0]              ram_word;
   logic [31:0]              fill_word;
   logic                     hit;
   logic                     flush_any;
   logic                     accept;
   logic                     unused_lo;

   assign req_tag   = req_addr[ADDR_WIDTH-1 -: TAG_BITS];
   assign req_index = req_addr[OFFSET_BITS+INDEX_BITS-1:OFFSET_BITS];
   assign req_word  = req_addr[OFFSET_BITS-1:2];
   assign f_index   =
      bus.fetch_addr_i[OFFSET_BITS+INDEX_BITS-1:OFFSET_BITS];
   assign unused_lo = ^bus.fetch_addr_i[1:0];

   assign ram_word  = bus.ram_data_i[{req_word, 5'd0} +: 32];
   assign fill_word = fill_buf[{req_word, 5'd0} +: 32];

   assign hit       = valid_q[req_index] &&
                      (tag_arr[req_index] == req_tag);
   assign flush_any = bus.flush_i || flush_pend;
   assign accept    = (state_q == IDLE) && rst && !flush_any &&
                      bus.fetch_req_i;

   always_comb begin
      state_d           = state_q;
      bus.fetch_gnt_o   = 1'b0;
      bus.fetch_valid_o = 1'b0;
      bus.fetch_instr_o = last_instr;
      bus.ram_addr_o    = '0;
      bus.ram_data_o    = '0;
      bus.ram_we_o      = 1'b0;
      bus.mem_req_o     = 1'b0;
      bus.mem_addr_o    = '0;
      unique case (state_q)
         IDLE: begin
            // rst gating keeps the grant and RAM address low while
            // reset is held, since IDLE is the reset state
            bus.fetch_gnt_o = rst && !flush_any;
            if (accept) begin
               bus.ram_addr_o = f_index;
               state_d        = LOOKUP;
            end
         end
         LOOKUP: begin
            if (hit) begin
               bus.fetch_valid_o = 1'b1;
               bus.fetch_instr_o = ram_word;
               state_d           = IDLE;
            end else begin
               state_d = MISS;
            end
         end
         MISS: begin
            bus.mem_req_o  = 1'b1;
            bus.mem_addr_o = {req_tag, req_index,
                              {OFFSET_BITS{1'b0}}};
            if (bus.mem_ack_i) begin
               state_d = FILL;
            end
         end
         FILL: begin
            bus.ram_we_o      = 1'b1;
            bus.ram_addr_o    = req_index;
            bus.ram_data_o    = fill_buf;
            bus.fetch_valid_o = 1'b1;
            bus.fetch_instr_o = fill_word;
            state_d           = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         valid_q    <= '0;
         flush_pend <= 1'b0;
         req_addr   <= '0;
         fill_buf   <= '0;
         last_instr <= '0;
      end else begin
         state_q <= state_d;
         // a flush seen mid-fetch is deferred to the next IDLE cycle,
         // so the line being filled is invalidated right after
         if (state_q == IDLE) begin
            if (flush_any) begin
               valid_q    <= '0;
               flush_pend <= 1'b0;
            end
         end else if (bus.flush_i) begin
            flush_pend <= 1'b1;
         end
         if (state_q == FILL) begin
            valid_q[req_index] <= 1'b1;
         end
         if (accept) begin
            req_addr <= bus.fetch_addr_i[ADDR_WIDTH-1:2];
         end
         if ((state_q == MISS) && bus.mem_ack_i) begin
            fill_buf <= bus.mem_data_i;
         end
         if (bus.fetch_valid_o) begin
            last_instr <= bus.fetch_instr_o;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (state_q == FILL) begin
         tag_arr[req_index] <= req_tag;
      end
   end
endmodule

// File: tb/tb_icache_ctrl.sv
// Testbench for icache_ctrl: directed test plan plus random fetches
// against a set/tag/line-memory reference model.
module tb_icache_ctrl;
   localparam int AW = 32;
   localparam int LW = 512;
   localparam int IB = 5;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   icache_ctrl_if #(
      .ADDR_WIDTH(AW), .LINE_WIDTH(LW), .INDEX_BITS(IB)
   ) bus ();

   icache_ctrl #(
      .ADDR_WIDTH(AW), .LINE_WIDTH(LW), .INDEX_BITS(IB)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // external data RAM: registered read, write on we
   logic [LW-1:0] ram_mem [32];
   always @(posedge clk) begin
      if (bus.ram_we_o) ram_mem[bus.ram_addr_o] <= bus.ram_data_o;
      bus.ram_data_i <= ram_mem[bus.ram_addr_o];
   end

   // reference model: per-set valid/tag, backing memory by line address
   bit            mv [32];
   logic [20:0]   mt [32];
   logic [LW-1:0] lines [int unsigned];

   int checks = 0;
   int failures = 0;

   initial begin
      #500000;
      $display("FAIL watchdog expired checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   function automatic logic [LW-1:0] line_of(input logic [31:0] a);
      int unsigned k;
      logic [LW-1:0] l;
      k = {a[31:6], 6'b0};
      if (!lines.exists(k)) begin
         for (int i = 0; i < LW / 32; i++) l[32*i +: 32] = $urandom;
         lines[k] = l;
      end
      return lines[k];
   endfunction

   task automatic chk(input string tag, input logic [LW-1:0] obs,
                      input logic [LW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_zero_outputs(input string tag);
      chk({tag, "_gnt"},   LW'(bus.fetch_gnt_o),   '0);
      chk({tag, "_valid"}, LW'(bus.fetch_valid_o), '0);
      chk({tag, "_instr"}, LW'(bus.fetch_instr_o), '0);
      chk({tag, "_we"},    LW'(bus.ram_we_o),      '0);
      chk({tag, "_raddr"}, LW'(bus.ram_addr_o),    '0);
      chk({tag, "_rdata"}, bus.ram_data_o,         '0);
      chk({tag, "_mreq"},  LW'(bus.mem_req_o),     '0);
      chk({tag, "_maddr"}, LW'(bus.mem_addr_o),    '0);
   endtask

   // mode 0: plain fetch; 1: flush pulse in MISS; 2: reset in MISS
   task automatic fetch(input logic [31:0] a, input int dly,
                        input int mode);
      int unsigned   idx;
      int unsigned   w;
      logic [20:0]   tg;
      logic [LW-1:0] ln;
      logic [31:0]   ew;
      bit            hit;
      bit            flushed;
      idx = a[10:6];
      w   = a[5:2];
      tg  = a[31:11];
      ln  = line_of(a);
      ew  = ln[32*w +: 32];
      hit = mv[idx] && (mt[idx] == tg);
      flushed = 1'b0;
      @(negedge clk);
      bus.fetch_req_i  = 1'b1;
      bus.fetch_addr_i = a;
      #1;
      chk("gnt", LW'(bus.fetch_gnt_o), LW'(1'b1));
      chk("rd_addr", LW'(bus.ram_addr_o), LW'(idx));
      @(negedge clk);
      bus.fetch_req_i  = 1'b0;
      bus.fetch_addr_i = $urandom;
      #1;
      chk("lookup_gnt", LW'(bus.fetch_gnt_o), '0);
      chk("lookup_mreq", LW'(bus.mem_req_o), '0);
      chk("hit", LW'(bus.fetch_valid_o), LW'(hit));
      if (hit) begin
         chk("hit_word", LW'(bus.fetch_instr_o), LW'(ew));
      end else begin
         @(negedge clk);
         if (mode == 1) begin
            bus.flush_i = 1'b1;
            flushed = 1'b1;
         end
         for (int k = 0; k < dly; k++) begin
            #1;
            chk("miss_mreq", LW'(bus.mem_req_o), LW'(1'b1));
            chk("miss_maddr", LW'(bus.mem_addr_o),
                LW'({a[31:6], 6'b0}));
            @(negedge clk);
            bus.flush_i = 1'b0;
         end
         #1;
         chk("ack_mreq", LW'(bus.mem_req_o), LW'(1'b1));
         chk("ack_maddr", LW'(bus.mem_addr_o), LW'({a[31:6], 6'b0}));
         if (mode == 2) begin
            rst = 1'b0;
            #1;
            chk_zero_outputs("rst_miss");
            mv = '{default: 1'b0};
            @(negedge clk);
            bus.flush_i = 1'b0;
            rst = 1'b1;
            return;
         end
         bus.mem_ack_i  = 1'b1;
         bus.mem_data_i = ln;
         @(negedge clk);
         bus.mem_ack_i  = 1'b0;
         bus.flush_i    = 1'b0;
         for (int i = 0; i < LW / 32; i++)
            bus.mem_data_i[32*i +: 32] = $urandom;
         #1;
         chk("fill_we", LW'(bus.ram_we_o), LW'(1'b1));
         chk("fill_addr", LW'(bus.ram_addr_o), LW'(idx));
         chk("fill_data", bus.ram_data_o, ln);
         chk("fill_valid", LW'(bus.fetch_valid_o), LW'(1'b1));
         chk("fill_word", LW'(bus.fetch_instr_o), LW'(ew));
         chk("fill_mreq", LW'(bus.mem_req_o), '0);
         mv[idx] = 1'b1;
         mt[idx] = tg;
      end
      @(negedge clk);
      #1;
      chk("idle_valid", LW'(bus.fetch_valid_o), '0);
      chk("idle_we", LW'(bus.ram_we_o), '0);
      chk("held_instr", LW'(bus.fetch_instr_o), LW'(ew));
      chk("idle_gnt", LW'(bus.fetch_gnt_o), LW'(!flushed));
      if (flushed) mv = '{default: 1'b0};
   endtask

   task automatic flush_idle(input bit with_req);
      @(negedge clk);
      bus.flush_i      = 1'b1;
      bus.fetch_req_i  = with_req;
      bus.fetch_addr_i = $urandom;
      #1;
      chk("flush_gnt", LW'(bus.fetch_gnt_o), '0);
      chk("flush_raddr", LW'(bus.ram_addr_o), '0);
      @(negedge clk);
      bus.flush_i     = 1'b0;
      bus.fetch_req_i = 1'b0;
      #1;
      chk("post_flush_gnt", LW'(bus.fetch_gnt_o), LW'(1'b1));
      chk("post_flush_valid", LW'(bus.fetch_valid_o), '0);
      mv = '{default: 1'b0};
   endtask

   task automatic stray_ack();
      @(negedge clk);
      bus.mem_ack_i  = 1'b1;
      bus.mem_data_i = {16{$urandom}};
      #1;
      chk("stray_gnt", LW'(bus.fetch_gnt_o), LW'(1'b1));
      chk("stray_mreq", LW'(bus.mem_req_o), '0);
      @(negedge clk);
      bus.mem_ack_i = 1'b0;
      #1;
      chk("stray_we", LW'(bus.ram_we_o), '0);
   endtask

   initial begin
      logic [LW-1:0] seed;
      logic [31:0]   a;
      int            r;
      bus.fetch_req_i  = 1'b0;
      bus.fetch_addr_i = '0;
      bus.flush_i      = 1'b0;
      bus.mem_ack_i    = 1'b0;
      bus.mem_data_i   = '0;
      repeat (2) @(negedge clk);
      bus.fetch_req_i  = 1'b1;
      bus.fetch_addr_i = 32'h0000_1044;
      #1;
      chk_zero_outputs("reset");
      @(negedge clk);
      bus.fetch_req_i = 1'b0;
      rst = 1'b1;

      seed = line_of(32'h0000_1040);
      seed[63:32] = 32'hDEADBEEF;
      lines[32'h0000_1040] = seed;

      fetch(32'h0000_1044, 3, 0);
      chk("t1_word", LW'(bus.fetch_instr_o), LW'(32'hDEADBEEF));
      fetch(32'h0000_1048, 0, 0);
      fetch(32'h0000_3044, 2, 0);
      fetch(32'h0000_1044, 1, 0);
      chk("t3_word", LW'(bus.fetch_instr_o), LW'(32'hDEADBEEF));

      fetch(32'h0000_2080, 0, 0);
      fetch(32'h0000_1040, 0, 0);
      flush_idle(1'b1);
      fetch(32'h0000_1044, 0, 0);
      fetch(32'h0000_2080, 1, 0);

      fetch(32'h0000_5100, 2, 1);
      fetch(32'h0000_5100, 0, 0);

      fetch(32'h0000_7200, 2, 2);
      fetch(32'h0000_7200, 1, 0);
      fetch(32'h0000_7204, 0, 0);

      for (int n = 0; n < 80; n++) begin
         a = (32'($urandom_range(0, 3)) << 11) |
             (32'($urandom_range(0, 3)) << 6) |
             (32'($urandom_range(0, 15)) << 2) |
             32'($urandom_range(0, 3));
         r = $urandom_range(0, 9);
         if (r == 0) begin
            flush_idle(1'($urandom_range(0, 1)));
         end else if (r == 1) begin
            fetch(a, $urandom_range(0, 4), 1);
         end else if (r == 2) begin
            stray_ack();
            fetch(a, $urandom_range(0, 4), 0);
         end else if (r == 3) begin
            fetch(a, $urandom_range(0, 4), 2);
         end else begin
            fetch(a, $urandom_range(0, 4), 0);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
